// File: rtl/qspi_multi_chan_arbiter.sv
// N-channel request arbiter for the QSPI control level: picks one upstream channel,
// forwards its instruction to the decoder, steers the shared data FIFOs and routes responses back.
module qspi_multi_chan_arbiter #(
    parameter int NCHAN       = 4,
    parameter int LBL_W       = 2,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_arb_mode,
    input  logic                     io_tdata_lock,
    input  logic                     io_tran_done,
    input  logic [NCHAN-1:0]         io_chan_req_valid,
    output logic [NCHAN-1:0]         io_chan_req_ready,
    input  logic [8*NCHAN-1:0]       io_chan_req_inst,
    input  logic [24*NCHAN-1:0]      io_chan_req_addr,
    input  logic [8*NCHAN-1:0]       io_chan_req_data_size,
    input  logic [8*NCHAN-1:0]       io_chan_req_data_burstlen,
    output logic [NCHAN-1:0]         io_chan_resp_valid,
    output logic [NCHAN-1:0]         io_chan_resp_error,
    output logic [2*NCHAN-1:0]       io_chan_resp_cause,
    input  logic [NCHAN-1:0]         io_chan_tdata_fifo_wen,
    input  logic [DATA_W*NCHAN-1:0]  io_chan_tdata_fifo_wdata,
    output logic [NCHAN-1:0]         io_chan_tdata_fifo_full,
    input  logic [NCHAN-1:0]         io_chan_rdata_fifo_ren,
    output logic [DATA_W-1:0]        io_chan_rdata_fifo_rdata,
    output logic [NCHAN-1:0]         io_chan_rdata_fifo_empty,
    output logic                     io_flash_req_valid,
    input  logic                     io_flash_req_ready,
    output logic [7:0]               io_flash_req_inst,
    output logic [23:0]              io_flash_req_addr,
    output logic [7:0]               io_flash_req_data_size,
    output logic [7:0]               io_flash_req_data_burstlen,
    output logic [LBL_W-1:0]         io_flash_req_inst_label,
    input  logic                     io_flash_resp_valid,
    input  logic                     io_flash_resp_error,
    input  logic [1:0]               io_flash_resp_cause,
    output logic                     io_tdata_fifo_wen,
    output logic [DATA_W-1:0]        io_tdata_fifo_wdata,
    input  logic                     io_tdata_fifo_full,
    output logic                     io_rdata_fifo_ren,
    input  logic [DATA_W-1:0]        io_rdata_fifo_rdata,
    input  logic                     io_rdata_fifo_empty
);

    localparam int INST_W  = 8;
    localparam int ADDR_W  = 24;
    localparam int SIZE_W  = 8;
    localparam int CAUSE_W = 2;
    localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_BUSY  = 2'b10
    } state_t;

    state_t             state_r, state_s;
    logic [LBL_W-1:0]   grant_r, grant_s;
    logic [LBL_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [NCHAN-1:0]   resp_valid_r, resp_valid_s;
    logic [NCHAN-1:0]   resp_error_r, resp_error_s;
    logic [2*NCHAN-1:0] resp_cause_r, resp_cause_s;
    logic [LBL_W-1:0]   winner_s;
    int                 gi_s;

    assign gi_s = int'(grant_r);

    // Arbitration winner; loops run from lowest to highest priority so the last hit wins
    always_comb begin
        winner_s = {LBL_W{1'b0}};
        if (io_arb_mode == 1'b0) begin
            for (int i = NCHAN - 1; i >= 0; i--) begin
                winner_s = io_chan_req_valid[i] ? LBL_W'(i) : winner_s;
            end
        end else begin
            for (int k = NCHAN; k >= 1; k--) begin
                winner_s = io_chan_req_valid[(int'(rr_ptr_r) + k) % NCHAN]
                         ? LBL_W'((int'(rr_ptr_r) + k) % NCHAN) : winner_s;
            end
        end
    end

    // Next-state, pointer, watchdog and response-pulse logic
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        rr_ptr_s     = rr_ptr_r;
        cnt_s        = cnt_r;
        resp_valid_s = {NCHAN{1'b0}};
        resp_error_s = {NCHAN{1'b0}};
        resp_cause_s = {(2*NCHAN){1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (!io_tdata_lock && (|io_chan_req_valid)) begin
                    grant_s = winner_s;
                    state_s = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A channel that withdraws before the handshake is dropped without a response
                if (!io_chan_req_valid[grant_r]) begin
                    state_s = ST_IDLE;
                end else if (io_flash_req_ready) begin
                    rr_ptr_s = grant_r;
                    cnt_s    = {CNT_W{1'b0}};
                    state_s  = ST_BUSY;
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_BUSY: begin
                if (io_flash_resp_valid && io_flash_resp_error) begin
                    resp_valid_s[grant_r] = 1'b1;
                    resp_error_s[grant_r] = 1'b1;
                    resp_cause_s[gi_s*CAUSE_W +: CAUSE_W] = io_flash_resp_cause;
                    state_s = ST_IDLE;
                end else if (io_tran_done) begin
                    resp_valid_s[grant_r] = 1'b1;
                    state_s = ST_IDLE;
                end else if (WDOG_EN && (cnt_r == CNT_LAST)) begin
                    resp_valid_s[grant_r] = 1'b1;
                    resp_error_s[grant_r] = 1'b1;
                    resp_cause_s[gi_s*CAUSE_W +: CAUSE_W] = 2'b11;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= {LBL_W{1'b0}};
            rr_ptr_r     <= LBL_W'(NCHAN - 1);
            cnt_r        <= {CNT_W{1'b0}};
            resp_valid_r <= {NCHAN{1'b0}};
            resp_error_r <= {NCHAN{1'b0}};
            resp_cause_r <= {(2*NCHAN){1'b0}};
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            rr_ptr_r     <= rr_ptr_s;
            cnt_r        <= cnt_s;
            resp_valid_r <= resp_valid_s;
            resp_error_r <= resp_error_s;
            resp_cause_r <= resp_cause_s;
        end
    end

    assign io_chan_resp_valid = resp_valid_r;
    assign io_chan_resp_error = resp_error_r;
    assign io_chan_resp_cause = resp_cause_r;

    // Request forwarding in GRANT and data-path steering in BUSY; idle values block every channel
    always_comb begin
        io_flash_req_valid         = 1'b0;
        io_flash_req_inst          = 8'h00;
        io_flash_req_addr          = 24'h000000;
        io_flash_req_data_size     = 8'h00;
        io_flash_req_data_burstlen = 8'h00;
        io_flash_req_inst_label    = {LBL_W{1'b0}};
        io_chan_req_ready          = {NCHAN{1'b0}};
        io_tdata_fifo_wen          = 1'b0;
        io_tdata_fifo_wdata        = {DATA_W{1'b0}};
        io_chan_tdata_fifo_full    = {NCHAN{1'b1}};
        io_rdata_fifo_ren          = 1'b0;
        io_chan_rdata_fifo_rdata   = {DATA_W{1'b0}};
        io_chan_rdata_fifo_empty   = {NCHAN{1'b1}};
        case (state_r)
            ST_GRANT: begin
                io_flash_req_valid         = 1'b1;
                io_flash_req_inst          = io_chan_req_inst[gi_s*INST_W +: INST_W];
                io_flash_req_addr          = io_chan_req_addr[gi_s*ADDR_W +: ADDR_W];
                io_flash_req_data_size     = io_chan_req_data_size[gi_s*SIZE_W +: SIZE_W];
                io_flash_req_data_burstlen = io_chan_req_data_burstlen[gi_s*SIZE_W +: SIZE_W];
                io_flash_req_inst_label    = grant_r;
                io_chan_req_ready[grant_r] = io_flash_req_ready;
            end
            ST_BUSY: begin
                io_tdata_fifo_wen                 = io_chan_tdata_fifo_wen[grant_r];
                io_tdata_fifo_wdata               = io_chan_tdata_fifo_wdata[gi_s*DATA_W +: DATA_W];
                io_chan_tdata_fifo_full[grant_r]  = io_tdata_fifo_full;
                io_rdata_fifo_ren                 = io_chan_rdata_fifo_ren[grant_r];
                io_chan_rdata_fifo_rdata          = io_rdata_fifo_rdata;
                io_chan_rdata_fifo_empty[grant_r] = io_rdata_fifo_empty;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_qspi_multi_chan_arbiter.sv
// Scoreboard bench for qspi_multi_chan_arbiter: a driver issues transactions and queues the
// expected grants/responses, an independent negedge monitor compares whatever the DUT presents.
module tb_qspi_multi_chan_arbiter;

    localparam int N  = 4;
    localparam int LW = 2;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic            io_arb_mode, io_tdata_lock, io_tran_done;
    logic [N-1:0]    io_chan_req_valid, io_chan_req_ready;
    logic [8*N-1:0]  io_chan_req_inst, io_chan_req_data_size, io_chan_req_data_burstlen;
    logic [24*N-1:0] io_chan_req_addr;
    logic [N-1:0]    io_chan_resp_valid, io_chan_resp_error;
    logic [2*N-1:0]  io_chan_resp_cause;
    logic [N-1:0]    io_chan_tdata_fifo_wen, io_chan_tdata_fifo_full;
    logic [DW*N-1:0] io_chan_tdata_fifo_wdata;
    logic [N-1:0]    io_chan_rdata_fifo_ren, io_chan_rdata_fifo_empty;
    logic [DW-1:0]   io_chan_rdata_fifo_rdata;
    logic            io_flash_req_valid, io_flash_req_ready;
    logic [7:0]      io_flash_req_inst, io_flash_req_data_size, io_flash_req_data_burstlen;
    logic [23:0]     io_flash_req_addr;
    logic [LW-1:0]   io_flash_req_inst_label;
    logic            io_flash_resp_valid, io_flash_resp_error;
    logic [1:0]      io_flash_resp_cause;
    logic            io_tdata_fifo_wen, io_tdata_fifo_full;
    logic [DW-1:0]   io_tdata_fifo_wdata;
    logic            io_rdata_fifo_ren, io_rdata_fifo_empty;
    logic [DW-1:0]   io_rdata_fifo_rdata;

    always #5 clock = ~clock;

    qspi_multi_chan_arbiter #(.NCHAN(N), .LBL_W(LW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clock(clock), .reset(reset),
        .io_arb_mode(io_arb_mode), .io_tdata_lock(io_tdata_lock), .io_tran_done(io_tran_done),
        .io_chan_req_valid(io_chan_req_valid), .io_chan_req_ready(io_chan_req_ready),
        .io_chan_req_inst(io_chan_req_inst), .io_chan_req_addr(io_chan_req_addr),
        .io_chan_req_data_size(io_chan_req_data_size), .io_chan_req_data_burstlen(io_chan_req_data_burstlen),
        .io_chan_resp_valid(io_chan_resp_valid), .io_chan_resp_error(io_chan_resp_error),
        .io_chan_resp_cause(io_chan_resp_cause),
        .io_chan_tdata_fifo_wen(io_chan_tdata_fifo_wen), .io_chan_tdata_fifo_wdata(io_chan_tdata_fifo_wdata),
        .io_chan_tdata_fifo_full(io_chan_tdata_fifo_full),
        .io_chan_rdata_fifo_ren(io_chan_rdata_fifo_ren), .io_chan_rdata_fifo_rdata(io_chan_rdata_fifo_rdata),
        .io_chan_rdata_fifo_empty(io_chan_rdata_fifo_empty),
        .io_flash_req_valid(io_flash_req_valid), .io_flash_req_ready(io_flash_req_ready),
        .io_flash_req_inst(io_flash_req_inst), .io_flash_req_addr(io_flash_req_addr),
        .io_flash_req_data_size(io_flash_req_data_size), .io_flash_req_data_burstlen(io_flash_req_data_burstlen),
        .io_flash_req_inst_label(io_flash_req_inst_label),
        .io_flash_resp_valid(io_flash_resp_valid), .io_flash_resp_error(io_flash_resp_error),
        .io_flash_resp_cause(io_flash_resp_cause),
        .io_tdata_fifo_wen(io_tdata_fifo_wen), .io_tdata_fifo_wdata(io_tdata_fifo_wdata),
        .io_tdata_fifo_full(io_tdata_fifo_full),
        .io_rdata_fifo_ren(io_rdata_fifo_ren), .io_rdata_fifo_rdata(io_rdata_fifo_rdata),
        .io_rdata_fifo_empty(io_rdata_fifo_empty)
    );

    typedef struct {
        int         ch;
        logic [7:0] inst;
        logic [23:0] addr;
        logic [7:0] size;
        logic [7:0] burst;
    } req_t;

    typedef struct {
        int         ch;
        logic       err;
        logic [1:0] cause;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   busy_ch = -1;
    int   rr_m    = N - 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration rule: lowest index, or first requester after the last winner
    function automatic int pick(input bit mode, input logic [N-1:0] v, input int rr);
        int w = -1;
        if (!mode) begin
            for (int i = 0; i < N; i++) if (w < 0 && v[i]) w = i;
        end else begin
            for (int k = 1; k <= N; k++) if (w < 0 && v[(rr + k) % N]) w = (rr + k) % N;
        end
        return w;
    endfunction

    task automatic rand_data();
        io_chan_tdata_fifo_wen   = 4'($urandom);
        io_chan_tdata_fifo_wdata = {$urandom, $urandom, $urandom, $urandom};
        io_chan_rdata_fifo_ren   = 4'($urandom);
        io_rdata_fifo_rdata      = $urandom;
        io_tdata_fifo_full       = 1'($urandom);
        io_rdata_fifo_empty      = 1'($urandom);
    endtask

    task automatic check_rst();
        chk("rst_chan_ctl", 64'({io_chan_req_ready, io_chan_resp_valid, io_chan_resp_error, io_chan_resp_cause}), 64'(0));
        chk("rst_chan_fifo", 64'({io_chan_tdata_fifo_full, io_chan_rdata_fifo_empty}), 64'(8'hFF));
        chk("rst_flash_req", 64'({io_flash_req_valid, io_flash_req_inst, io_flash_req_addr, io_flash_req_data_size,
                                  io_flash_req_data_burstlen, io_flash_req_inst_label}), 64'(0));
        chk("rst_shared_ctl", 64'({io_tdata_fifo_wen, io_rdata_fifo_ren}), 64'(0));
        chk("rst_wdata", 64'(io_tdata_fifo_wdata), 64'(0));
        chk("rst_rdata", 64'(io_chan_rdata_fifo_rdata), 64'(0));
    endtask

    // Monitor: compares grants, responses and FIFO steering against the queued expectations
    always @(negedge clock) begin
        req_t r;
        rsp_t s;
        logic [N-1:0] ef, ee, ev;
        if (!reset) begin
            if (io_flash_req_valid) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 64'(io_flash_req_valid), 64'(0));
                end else begin
                    r = req_q[0];
                    chk("req_ready_vec", 64'(io_chan_req_ready), io_flash_req_ready ? 64'(4'b0001 << r.ch) : 64'(0));
                    if (io_flash_req_ready) begin
                        void'(req_q.pop_front());
                        chk("req_label", 64'(io_flash_req_inst_label), 64'(r.ch));
                        chk("req_inst", 64'(io_flash_req_inst), 64'(r.inst));
                        chk("req_addr", 64'(io_flash_req_addr), 64'(r.addr));
                        chk("req_size", 64'(io_flash_req_data_size), 64'(r.size));
                        chk("req_burst", 64'(io_flash_req_data_burstlen), 64'(r.burst));
                    end
                end
            end else begin
                chk("req_ready_idle", 64'(io_chan_req_ready), 64'(0));
            end
            if (|io_chan_resp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("resp_unexpected", 64'(io_chan_resp_valid), 64'(0));
                end else begin
                    s  = rsp_q.pop_front();
                    ev = 4'(4'b0001 << s.ch);
                    chk("resp_valid", 64'(io_chan_resp_valid), 64'(ev));
                    chk("resp_error", 64'(io_chan_resp_error), s.err ? 64'(ev) : 64'(0));
                    chk("resp_cause", 64'(io_chan_resp_cause), 64'(8'(s.cause) << (2 * s.ch)));
                end
            end
            if (busy_ch >= 0) begin
                ef = 4'hF; ef[busy_ch] = io_tdata_fifo_full;
                ee = 4'hF; ee[busy_ch] = io_rdata_fifo_empty;
                chk("tx_wen", 64'(io_tdata_fifo_wen), 64'(io_chan_tdata_fifo_wen[busy_ch]));
                chk("tx_wdata", 64'(io_tdata_fifo_wdata), 64'(io_chan_tdata_fifo_wdata[busy_ch*DW +: DW]));
                chk("tx_full", 64'(io_chan_tdata_fifo_full), 64'(ef));
                chk("rx_ren", 64'(io_rdata_fifo_ren), 64'(io_chan_rdata_fifo_ren[busy_ch]));
                chk("rx_rdata", 64'(io_chan_rdata_fifo_rdata), 64'(io_rdata_fifo_rdata));
                chk("rx_empty", 64'(io_chan_rdata_fifo_empty), 64'(ee));
            end else begin
                chk("idle_fifo", 64'({io_tdata_fifo_wen, io_rdata_fifo_ren, io_chan_tdata_fifo_full,
                                      io_chan_rdata_fifo_empty}), 64'(10'h0FF));
            end
        end
    end

    // kind: 0 done, 1 decoder error, 2 watchdog timeout, 3 reset mid-transfer
    task automatic do_txn(input bit mode, input logic [N-1:0] vmask, input int kind, input int dly,
                          input int lock_cyc, input int rdy_dly, input logic [1:0] cause);
        int   g, n, last;
        bit   hs;
        req_t r;
        rsp_t s;
        for (int i = 0; i < N; i++) begin
            io_chan_req_inst[i*8 +: 8]          = 8'($urandom);
            io_chan_req_addr[i*24 +: 24]        = 24'($urandom);
            io_chan_req_data_size[i*8 +: 8]     = 8'($urandom);
            io_chan_req_data_burstlen[i*8 +: 8] = 8'($urandom);
        end
        g       = pick(mode, vmask, rr_m);
        r.ch    = g;
        r.inst  = io_chan_req_inst[g*8 +: 8];
        r.addr  = io_chan_req_addr[g*24 +: 24];
        r.size  = io_chan_req_data_size[g*8 +: 8];
        r.burst = io_chan_req_data_burstlen[g*8 +: 8];
        req_q.push_back(r);
        io_arb_mode        = mode;
        io_tdata_lock      = (lock_cyc > 0);
        io_chan_req_valid  = vmask;
        io_flash_req_ready = (rdy_dly == 0);
        for (int i = 0; i < lock_cyc; i++) begin
            @(negedge clock);
            chk("lock_hold", 64'(io_flash_req_valid), 64'(0));
            @(posedge clock); #1;
        end
        io_tdata_lock = 1'b0;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 40) begin
            @(negedge clock);
            if (io_flash_req_valid && io_flash_req_ready) hs = 1'b1;
            else begin
                @(posedge clock); #1;
                n++;
                if (n >= rdy_dly) io_flash_req_ready = 1'b1;
            end
        end
        if (!hs) begin
            chk("handshake_seen", 64'(hs), 64'(1));
            req_q.delete();
            io_chan_req_valid = '0;
            return;
        end
        @(posedge clock); #1;
        rr_m               = g;
        io_chan_req_valid  = '0;
        io_flash_req_ready = 1'b0;
        busy_ch            = g;
        last = (kind == 2) ? TO : dly;
        for (int c = 1; c < last; c++) begin
            rand_data();
            io_tdata_lock       = ($urandom % 4 == 0);
            io_flash_resp_valid = ($urandom % 5 == 0);
            io_flash_resp_error = 1'b0;
            io_flash_resp_cause = 2'($urandom);
            @(posedge clock); #1;
        end
        rand_data();
        io_flash_resp_valid = 1'b0;
        io_flash_resp_error = 1'b0;
        s.ch = g; s.err = 1'b0; s.cause = 2'b00;
        if (kind == 3) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset   = 1'b0;
            busy_ch = -1;
            rr_m    = N - 1;
            @(negedge clock);
            check_rst();
        end else begin
            if (kind == 0) io_tran_done = 1'b1;
            else if (kind == 1) begin
                io_flash_resp_valid = 1'b1;
                io_flash_resp_error = 1'b1;
                io_flash_resp_cause = cause;
                s.err = 1'b1; s.cause = cause;
            end else begin
                s.err = 1'b1; s.cause = 2'b11;
            end
            rsp_q.push_back(s);
            @(posedge clock); #1;
            io_tran_done        = 1'b0;
            io_flash_resp_valid = 1'b0;
            io_flash_resp_error = 1'b0;
            busy_ch             = -1;
            @(negedge clock); #1;
            chk("resp_pending", 64'(rsp_q.size()), 64'(0));
            rsp_q.delete();
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL sim_time_limit: got no finish expected finish before limit");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        io_arb_mode = 1'b0; io_tdata_lock = 1'b0; io_tran_done = 1'b0;
        io_chan_req_valid = '0; io_chan_req_inst = '0; io_chan_req_addr = '0;
        io_chan_req_data_size = '0; io_chan_req_data_burstlen = '0;
        io_flash_req_ready = 1'b0; io_flash_resp_valid = 1'b0; io_flash_resp_error = 1'b0;
        io_flash_resp_cause = 2'b00;
        rand_data();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_rst();
        @(posedge clock); #1;
        reset = 1'b0;

        do_txn(1'b0, 4'b1010, 0, 3, 0, 0, 2'b00);
        do_txn(1'b0, 4'b1000, 0, 2, 0, 1, 2'b00);
        for (int i = 0; i < 5; i++) do_txn(1'b1, 4'b1111, 0, 1 + i, 0, 0, 2'b00);
        do_txn(1'b0, 4'b0100, 0, 2, 10, 0, 2'b00);
        do_txn(1'b0, 4'b1000, 1, 4, 0, 0, 2'b01);
        do_txn(1'b0, 4'b0001, 2, 1, 0, 0, 2'b00);
        do_txn(1'b0, 4'b0001, 0, 16, 0, 2, 2'b00);
        do_txn(1'b1, 4'b0010, 3, 5, 0, 0, 2'b00);
        do_txn(1'b1, 4'b1111, 0, 2, 0, 0, 2'b00);

        for (int t = 0; t < 60; t++) begin
            int k, kind;
            k    = $urandom % 10;
            kind = (k < 5) ? 0 : (k < 7) ? 1 : (k < 9) ? 2 : 3;
            do_txn(1'($urandom), 4'($urandom_range(1, 15)), kind, $urandom_range(1, 16),
                   $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom));
        end

        repeat (3) @(posedge clock);
        chk("req_q_drained", 64'(req_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
